// File: rtl/seq_scan_ctrl.sv
// Serial bit-pattern scanner: counts matches of a configurable pattern over a
// bounded window or hit limit, with optional overlapping matches.
module seq_scan_ctrl #(
    parameter int unsigned PMAX = 8,
    parameter int unsigned CW   = 16
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic            abort,
    input  logic [PMAX-1:0] cfg_pattern,
    input  logic [3:0]      cfg_len,
    input  logic            cfg_overlap,
    input  logic [CW-1:0]   cfg_window,
    input  logic [CW-1:0]   cfg_max_hits,
    input  logic            bit_in,
    input  logic            bit_valid,
    output logic            bit_ready,
    output logic            hit,
    output logic [CW-1:0]   hit_count,
    output logic [CW-1:0]   bits_seen,
    output logic            busy,
    output logic            done,
    output logic            err
);

    localparam int unsigned LW = 4;
    localparam logic [LW-1:0] PMAX_L = LW'(PMAX);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_e;

    state_e            state_q, state_d;
    logic [PMAX-2:0]   hist_q, hist_d;
    logic [LW-1:0]     fill_q, fill_d;
    logic [CW-1:0]     hits_q, hits_d;
    logic [CW-1:0]     bits_q, bits_d;
    logic [PMAX-1:0]   pat_q, pat_d;
    logic [LW-1:0]     len_q, len_d;
    logic              ovl_q, ovl_d;
    logic [CW-1:0]     win_q, win_d;
    logic [CW-1:0]     max_q, max_d;
    logic              hit_q, hit_d;
    logic              done_q, done_d;
    logic              err_q, err_d;

    logic [PMAX-1:0]   hist_nx;
    logic [PMAX-1:0]   len_mask;
    logic [LW-1:0]     fill_nx;
    logic [CW-1:0]     hits_nx;
    logic [CW-1:0]     bits_nx;
    logic              match;
    logic              accept;
    logic              len_ok;

    // Post-shift view of the history used for match and end-of-scan decisions
    always_comb begin
        hist_nx  = {hist_q, bit_in};
        fill_nx  = (fill_q == PMAX_L) ? fill_q : fill_q + LW'(1);
        len_mask = '0;
        for (int i = 0; i < int'(PMAX); i++) begin
            len_mask[i] = (LW'(i) < len_q);
        end
        match    = (fill_nx >= len_q) && ((hist_nx & len_mask) == (pat_q & len_mask));
        hits_nx  = (match && (hits_q != '1)) ? hits_q + CW'(1) : hits_q;
        bits_nx  = (bits_q == '1) ? bits_q : bits_q + CW'(1);
        accept   = bit_valid && (state_q == S_RUN);
        len_ok   = (cfg_len != '0) && (cfg_len <= PMAX_L);
    end

    always_comb begin
        state_d = state_q;
        hist_d  = hist_q;
        fill_d  = fill_q;
        hits_d  = hits_q;
        bits_d  = bits_q;
        pat_d   = pat_q;
        len_d   = len_q;
        ovl_d   = ovl_q;
        win_d   = win_q;
        max_d   = max_q;
        hit_d   = 1'b0;
        done_d  = 1'b0;
        err_d   = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    if (len_ok) begin
                        pat_d   = cfg_pattern;
                        len_d   = cfg_len;
                        ovl_d   = cfg_overlap;
                        win_d   = cfg_window;
                        max_d   = cfg_max_hits;
                        hist_d  = '0;
                        fill_d  = '0;
                        hits_d  = '0;
                        bits_d  = '0;
                        state_d = S_RUN;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            S_RUN: begin
                if (accept) begin
                    hist_d = hist_nx[PMAX-2:0];
                    fill_d = (match && !ovl_q) ? '0 : fill_nx;
                    hits_d = hits_nx;
                    bits_d = bits_nx;
                    hit_d  = match;
                    if (((win_q != '0) && (bits_nx == win_q)) ||
                        ((max_q != '0) && (hits_nx == max_q))) begin
                        state_d = S_DONE;
                        done_d  = 1'b1;
                    end
                end
                // Abort wins over completion; the last bit is still counted
                if (abort) begin
                    state_d = S_IDLE;
                    done_d  = 1'b0;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            hist_q  <= '0;
            fill_q  <= '0;
            hits_q  <= '0;
            bits_q  <= '0;
            pat_q   <= '0;
            len_q   <= '0;
            ovl_q   <= 1'b0;
            win_q   <= '0;
            max_q   <= '0;
            hit_q   <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            hist_q  <= hist_d;
            fill_q  <= fill_d;
            hits_q  <= hits_d;
            bits_q  <= bits_d;
            pat_q   <= pat_d;
            len_q   <= len_d;
            ovl_q   <= ovl_d;
            win_q   <= win_d;
            max_q   <= max_d;
            hit_q   <= hit_d;
            done_q  <= done_d;
            err_q   <= err_d;
        end
    end

    assign bit_ready = (state_q == S_RUN);
    assign busy      = (state_q == S_RUN);
    assign hit       = hit_q;
    assign done      = done_q;
    assign err       = err_q;
    assign hit_count = hits_q;
    assign bits_seen = bits_q;

endmodule

// File: doc/seq_scan_ctrl.md
SEQ_SCAN_CTRL -- requirements
Module: seq_scan_ctrl

Interface
REQ-001 SHALL have parameter PMAX, default 8: maximum pattern length in bits (legal 2..15).
REQ-002 SHALL have parameter CW, default 16: width of the window, hit-limit and count fields.
REQ-003 SHALL have port clk  input  1  clock; all state changes on its rising edge.
REQ-004 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-005 SHALL have port start  input  1  one-cycle request to begin a scan with the current cfg_* values.
REQ-006 SHALL have port abort  input  1  terminates a running scan without done.
REQ-007 SHALL have port cfg_pattern  input  PMAX  target sequence; bit [cfg_len-1] is the first bit received.
REQ-008 SHALL have port cfg_len  input  4  pattern length; legal range 1..PMAX.
REQ-009 SHALL have port cfg_overlap  input  1  1 = overlapping matches allowed; 0 = history restarts after each hit.
REQ-010 SHALL have port cfg_window  input  CW  number of bits to scan; 0 = unbounded.
REQ-011 SHALL have port cfg_max_hits  input  CW  hit count that ends the scan; 0 = no limit.
REQ-012 SHALL have port bit_in  input  1  serial data bit.
REQ-013 SHALL have port bit_valid  input  1  bit_in is valid this cycle.
REQ-014 SHALL have port bit_ready  output  1  controller accepts a bit this cycle.
REQ-015 SHALL have port hit  output  1  one-cycle pulse per detected match.
REQ-016 SHALL have port hit_count  output  CW  matches in the current or last scan.
REQ-017 SHALL have port bits_seen  output  CW  bits accepted in the current or last scan.
REQ-018 SHALL have port busy  output  1  high in RUN.
REQ-019 SHALL have port done  output  1  one-cycle pulse at normal scan completion.
REQ-020 SHALL have port err  output  1  one-cycle pulse on a rejected start.

Function
REQ-021 SHALL implement FSM states IDLE, RUN, DONE.
REQ-022 IDLE + start with legal cfg_len: SHALL latch all cfg_* values, clear history, fill count, hit_count and bits_seen, and enter RUN next cycle.
REQ-023 IDLE + start with cfg_len 0 or >PMAX: SHALL pulse err next cycle, stay IDLE, leave counters unchanged.
REQ-024 start while in RUN or DONE SHALL be ignored; cfg_* changes after latching SHALL have no effect.
REQ-025 bit_ready SHALL equal (state==RUN); a bit is accepted when bit_valid && bit_ready.
REQ-026 Per accepted bit: history <= {history[PMAX-2:0], bit_in}; fill count increments, saturating at PMAX; bits_seen increments, saturating at 2^CW-1.
REQ-027 Match SHALL be fill_next >= len and history_next[len-1:0] == pattern[len-1:0], evaluated on the post-shift history.
REQ-028 On a match: hit SHALL pulse the cycle after acceptance; hit_count SHALL increment, saturating at 2^CW-1.
REQ-029 After a match with latched overlap=0, fill count SHALL reset to 0; with overlap=1 it SHALL be retained.
REQ-030 RUN -> DONE when, after an accepted bit, bits_seen_next == window (window != 0) or hit_count_next == max_hits (max_hits != 0).
REQ-031 DONE SHALL last exactly one cycle with done=1, then return to IDLE; hit for the final bit SHALL coincide with done.
REQ-032 abort in RUN SHALL send the FSM to IDLE next cycle with no done pulse.
REQ-033 abort and an accepted bit in the same cycle: the bit SHALL still be counted and may hit; abort SHALL override the DONE transition.
REQ-034 hit_count and bits_seen SHALL hold their values in IDLE until the next legal start.
REQ-035 abort outside RUN SHALL have no effect.

Reset
REQ-036 rst SHALL force state IDLE and clear history, fill count, hit_count, bits_seen, latched configuration, hit, done, err and busy immediately.
REQ-037 rst mid-scan SHALL discard the scan; no done or hit SHALL follow reset release.

Verification
REQ-038 pattern=01110, len=5, overlap=0, window=10; stream 0111001110 -> hit after bits 5 and 10, done with the final hit, hit_count=2, bits_seen=10.
REQ-039 pattern=0101, len=4, overlap=1 vs 0; stream 0101010 -> hit_count=2 with overlap=1, 1 with overlap=0.
REQ-040 max_hits=1, window=0, pattern=11, len=2; stream 0011 -> done after the 4th bit, bit_ready=0 afterwards, hit_count=1.
REQ-041 start with cfg_len=0, then cfg_len=9 (PMAX=8) -> err pulse each time, busy stays 0.
REQ-042 bit_valid toggling 1,0,1,0 during RUN -> only valid cycles counted; abort on the 3rd bit with a hit -> hit=1, no done, bits_seen=3.
REQ-043 rst asserted mid-scan with bits_seen=4 -> all outputs 0 asynchronously; next legal start begins from clear counters.
